ntt_ctrl: RTL and testbench

Sequencer that drives the ML-DSA-65 NTT/INTT butterfly datapath for one 256-coefficient polynomial. It walks all 8 layers and emits one coefficient-pair read per cycle to the dual-port coefficient RAM. In the same cycle it emits a twiddle ROM index, so the twiddle arrives at the butterfly together with the operands. It delays the pair addresses by the RAM + butterfly latency to generate write-back, and stalls at each layer boundary until the pipeline drains, which removes read-after-write hazards.

---
 rtl/ntt_ctrl_if.sv | 28 ++
 rtl/ntt_ctrl.sv | 151 +++++++++++++++
 tb/tb_ntt_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ntt_ctrl_if.sv
// Handshake and RAM/ROM/butterfly strobe bundle between the NTT sequencer and its datapath.
interface ntt_ctrl_if;
    logic       start;
    logic       intt;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [7:0] tw_idx;
    logic       bfu_intt;
    logic       bfu_skip;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        input  start, intt,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
               bfu_intt, bfu_skip, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, intt,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
               bfu_intt, bfu_skip, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_ctrl.sv
// ML-DSA NTT/INTT sequencer: issues 8 layers x 128 butterfly pairs, delays pair
// addresses into write-back, and drains the pipeline at every layer boundary.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one coefficient pair read per cycle, i = 0..127
// DRAIN | WL cycles for in-flight pairs to write back
// DONE  | one-cycle completion pulse
module ntt_ctrl #(
    parameter int RAM_LAT = 1,
    parameter int BFU_LAT = 4
) (
    input logic        clk,
    input logic        rst,
    ntt_ctrl_if.master bus
);
    localparam int WL = RAM_LAT + BFU_LAT;
    localparam int CW = ($clog2(WL) > 0) ? $clog2(WL) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [2:0]    layer, layer_nxt;
    logic [6:0]    idx, idx_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          mode, mode_nxt;

    logic          busy_q, done_q, rd_en_q;
    logic [7:0]    rd_a_q, rd_b_q, tw_q;

    logic          pv   [WL];
    logic [7:0]    pa_q [WL];
    logic [7:0]    pb_q [WL];

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        idx_nxt   = idx;
        wait_nxt  = wait_cnt;
        mode_nxt  = mode;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mode_nxt  = bus.intt;
                    layer_nxt = 3'd0;
                    idx_nxt   = 7'd0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (idx == 7'd127) begin
                    state_nxt = S_DRAIN;
                    wait_nxt  = CW'(WL - 1);
                end else begin
                    idx_nxt = idx + 7'd1;
                end
            end
            S_DRAIN: begin
                if (wait_cnt == '0) begin
                    if (layer == 3'd7) begin
                        state_nxt = S_DONE;
                    end else begin
                        layer_nxt = layer + 3'd1;
                        idx_nxt   = 7'd0;
                        state_nxt = S_ISSUE;
                    end
                end else begin
                    wait_nxt = wait_cnt - CW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pair geometry is derived from the next-cycle counters so the registered
    // read strobe appears in the same cycle the FSM enters/continues ISSUE.
    logic       issue_nxt;
    logic [2:0] sh;
    logic [7:0] ii, grp, off, pair_a, pair_b, pair_tw;
    logic [8:0] tw_inv;

    always_comb begin
        issue_nxt = (state_nxt == S_ISSUE);
        sh        = mode_nxt ? layer_nxt : (3'd7 - layer_nxt);
        ii        = {1'b0, idx_nxt};
        grp       = ii >> sh;
        off       = ii & ((8'd1 << sh) - 8'd1);
        pair_a    = (grp << ({1'b0, sh} + 4'd1)) | off;
        pair_b    = pair_a + (8'd1 << sh);
        tw_inv    = (9'd1 << (4'd8 - {1'b0, layer_nxt})) - 9'd1 - {1'b0, grp};
        pair_tw   = mode_nxt ? tw_inv[7:0] : ((8'd1 << layer_nxt) + grp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            layer    <= 3'd0;
            idx      <= 7'd0;
            wait_cnt <= '0;
            mode     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_a_q   <= 8'd0;
            rd_b_q   <= 8'd0;
            tw_q     <= 8'd0;
            for (int k = 0; k < WL; k++) begin
                pv[k]   <= 1'b0;
                pa_q[k] <= 8'd0;
                pb_q[k] <= 8'd0;
            end
        end else begin
            state    <= state_nxt;
            layer    <= layer_nxt;
            idx      <= idx_nxt;
            wait_cnt <= wait_nxt;
            mode     <= mode_nxt;
            busy_q   <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
            done_q   <= (state_nxt == S_DONE);
            rd_en_q  <= issue_nxt;
            rd_a_q   <= issue_nxt ? pair_a  : 8'd0;
            rd_b_q   <= issue_nxt ? pair_b  : 8'd0;
            tw_q     <= issue_nxt ? pair_tw : 8'd0;
            // Idle read strobes carry zero addresses, so write-back is zero when invalid.
            pv[0]    <= rd_en_q;
            pa_q[0]  <= rd_a_q;
            pb_q[0]  <= rd_b_q;
            for (int k = 1; k < WL; k++) begin
                pv[k]   <= pv[k-1];
                pa_q[k] <= pa_q[k-1];
                pb_q[k] <= pb_q[k-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_idx    = tw_q;
    assign bus.bfu_intt  = mode;
    assign bus.bfu_skip  = 1'b0;
    assign bus.wr_en     = pv[WL-1];
    assign bus.wr_addr_a = pa_q[WL-1];
    assign bus.wr_addr_b = pb_q[WL-1];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: stimulus queues expected reads/writes/done,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ntt_ctrl;
    logic clk = 1'b0;
    logic rst;

    ntt_ctrl_if bus ();

    ntt_ctrl #(.RAM_LAT(1), .BFU_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int mode;
    } ent_t;

    ent_t rd_q[$];
    ent_t wr_q[$];
    ent_t hv_q[$];
    int   done_q[$];

    int cyc      = 0;
    int n_vec    = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int run_base = 0;
    bit pend[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ent_t model(input int l, input int i, input int m, input int c);
        int   len, g, off;
        ent_t e;
        len    = m ? (1 << l) : (128 >> l);
        g      = i / len;
        off    = i % len;
        e.cyc  = c;
        e.a    = 2 * len * g + off;
        e.b    = e.a + len;
        e.tw   = m ? ((1 << (8 - l)) - 1 - g) : ((1 << l) + g);
        e.mode = m;
        return e;
    endfunction

    function automatic ent_t mk(input int c, input int a, input int b, input int tw);
        ent_t e;
        e.cyc = c; e.a = a; e.b = b; e.tw = tw; e.mode = 0;
        return e;
    endfunction

    // Called at a negedge; that cycle becomes cycle 0 of the run.
    task automatic start_run(input int m);
        int   base;
        ent_t e;
        base     = cyc;
        run_base = base;
        wr_cnt   = 0;
        bus.start = 1'b1;
        bus.intt  = m[0];
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 128; i++) begin
                e = model(l, i, m, base + 1 + l * 133 + i);
                rd_q.push_back(e);
                e.cyc = e.cyc + 5;
                wr_q.push_back(e);
            end
        end
        done_q.push_back(base + 1065);
        if (m == 0) begin
            hv_q.push_back(mk(base + 1,   0, 128,   1));
            hv_q.push_back(mk(base + 128, 127, 255, 1));
            hv_q.push_back(mk(base + 134, 0,  64,   2));
            hv_q.push_back(mk(base + 198, 128, 192, 3));
            hv_q.push_back(mk(base + 937, 10, 11, 133));
        end else begin
            hv_q.push_back(mk(base + 1,   0,   1, 255));
            hv_q.push_back(mk(base + 128, 254, 255, 128));
            hv_q.push_back(mk(base + 410, 18,  26, 30));
            hv_q.push_back(mk(base + 932, 0,  128, 1));
            hv_q.push_back(mk(base + 1059, 127, 255, 1));
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.intt  = ~m[0];
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, bus.busy, bus.done, bus.rd_en, bus.bfu_intt, bus.bfu_skip, bus.wr_en}, 0);
        chk({tag, "_rd"}, {8'd0, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx}, 0);
        chk({tag, "_wr"}, {16'd0, bus.wr_addr_a, bus.wr_addr_b}, 0);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            rd_q.delete();
            wr_q.delete();
            hv_q.delete();
            done_q.delete();
            for (int k = 0; k < 256; k++) pend[k] = 1'b0;
        end else begin
            chk("bfu_skip", bus.bfu_skip, 0);
            if (bus.wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) chk("wr_unexpected", bus.wr_en, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr_a", bus.wr_addr_a, e.a);
                    chk("wr_addr_b", bus.wr_addr_b, e.b);
                end
                pend[bus.wr_addr_a] = 1'b0;
                pend[bus.wr_addr_b] = 1'b0;
            end else begin
                chk("wr_idle_zero", {16'd0, bus.wr_addr_a, bus.wr_addr_b}, 0);
            end
            if (bus.rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", bus.rd_en, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr_a", bus.rd_addr_a, e.a);
                    chk("rd_addr_b", bus.rd_addr_b, e.b);
                    chk("tw_idx", bus.tw_idx, e.tw);
                    chk("bfu_intt", bus.bfu_intt, e.mode);
                    chk("busy_issue", bus.busy, 1);
                end
                chk("rd_hazard", pend[bus.rd_addr_a] | pend[bus.rd_addr_b], 0);
                pend[bus.rd_addr_a] = 1'b1;
                pend[bus.rd_addr_b] = 1'b1;
            end else begin
                chk("rd_idle_zero", {8'd0, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx}, 0);
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("done_unexpected", bus.done, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
                chk("busy_at_done", bus.busy, 0);
            end
            if (hv_q.size() > 0 && hv_q[0].cyc == cyc) begin
                e = hv_q.pop_front();
                chk("hv_rd_en", bus.rd_en, 1);
                chk("hv_addr_a", bus.rd_addr_a, e.a);
                chk("hv_addr_b", bus.rd_addr_b, e.b);
                chk("hv_tw_idx", bus.tw_idx, e.tw);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.intt  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Run 1: forward, stray starts at cycles 10 and 1065, back-to-back start at 1066.
        start_run(0);
        wait_until(run_base + 10);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(run_base + 1065);
        bus.start = 1'b1;
        @(negedge clk);
        chk("write_count_run1", wr_cnt, 1024);
        start_run(1);

        // Run 2: inverse.
        wait_until(run_base + 1068);
        chk("write_count_run2", wr_cnt, 1024);

        // Run 3: inverse, async reset mid-run with writes in flight.
        start_run(1);
        wait_until(run_base + 300);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wr_cnt = 0;
        repeat (30) @(negedge clk);
        chk("writes_after_rst", wr_cnt, 0);
        check_zero("post_rst_idle");

        // Run 4: forward, full sequence after the reset.
        start_run(0);
        wait_until(run_base + 1070);
        chk("write_count_run4", wr_cnt, 1024);

        chk("rd_left", rd_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("hv_left", hv_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
